// File: rtl/nandgame_pkg.sv
// Shared types for the nandgame memory-side blocks.
// The SUM encoding is reserved even when MEM_DUMP_CHECKSUM_EN is not defined.
package nandgame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        SUM  = 2'd3
    } mem_dump_state_t;

endpackage

// File: rtl/dump_addr_gen.sv
// Address register and remaining-word down-counter for mem_dump.
// The address wraps modulo 2^ADDR_WIDTH.
module dump_addr_gen #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= base_addr;
            cnt  <= length;
        end else if (step) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - 1'b1;
        end
    end

    assign last = (cnt == ADDR_WIDTH'(1));

endmodule

// File: rtl/mem_dump.sv
// Memory read-out engine: walks a RAM range through a read port and streams it out.
// Define MEM_DUMP_CHECKSUM_EN to append a modulo-2^WIDTH checksum word to every dump.
module mem_dump
    import nandgame_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_data,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_data/out_last stay stable while out_valid is high and out_ready is low.
    mem_dump_state_t state, state_next;
    logic            xfer;
    logic            last;
    logic            ag_load;
    logic            ag_step;

    assign xfer      = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    dump_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .step      (ag_step),
        .base_addr (base_addr),
        .length    (length),
        .addr      (mem_addr),
        .last      (last)
    );

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sum;

    assign acc_sum = acc + out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
        end else if (state == SEND && xfer) begin
            acc <= acc_sum;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    state_next = (length != '0) ? LOAD : SUM;
`else
                    state_next = (length != '0) ? LOAD : IDLE;
`endif
                end
            end
            LOAD: state_next = SEND;
            SEND: begin
                if (xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    state_next = last ? SUM : LOAD;
`else
                    state_next = last ? IDLE : LOAD;
`endif
                end
            end
            SUM:     if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ag_load = (state == IDLE) && start && (length != '0);
        ag_step = (state == SEND) && xfer && !last;
    end

    // Output register: captured in LOAD, held through SEND until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && length == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        out_data  <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
`else
                        done <= 1'b1;
`endif
                    end
                end
                LOAD: begin
                    out_data  <= mem_data;
                    out_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= last;
`endif
                end
                SEND: begin
                    if (xfer) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        if (last) begin
                            out_data <= acc_sum;
                            out_last <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
`else
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (last) done <= 1'b1;
`endif
                    end
                end
                SUM: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump: basic, backpressure, wrap, zero-length, stray start, reset.
// Build with MEM_DUMP_CHECKSUM_EN to expect the trailing checksum word.
module tb_mem_dump;
    import nandgame_pkg::*;

    localparam int WIDTH = 16;
    localparam int AW    = 16;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   length;
    logic [AW-1:0]   mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;

    logic [WIDTH-1:0] ram [0:65535];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic             last_q[$];
    logic [AW-1:0]    addr_q[$];
    int               done_cyc;
    int               checks;
    int               errors;

    mem_dump #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    assign mem_data = ram[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the start edge.
    task automatic collect(input int stall, input bit stray, input int max_cyc);
        int cyc;
        int st;
        bit have;
        logic [WIDTH-1:0] held;
        got_q.delete();
        last_q.delete();
        addr_q.delete();
        done_cyc = -1;
        cyc  = 1;
        st   = 0;
        have = 1'b0;
        held = '0;
        while (cyc <= max_cyc) begin
            if (stray) begin
                if (cyc == 2) begin
                    start     = 1'b1;
                    base_addr = 16'h0040;
                    length    = 16'd1;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (out_valid) begin
                if (have) chk("stall_hold", 32'(out_data), 32'(held));
                else begin
                    held = out_data;
                    have = 1'b1;
                end
                if (st < stall) begin
                    out_ready = 1'b0;
                    st++;
                end else begin
                    out_ready = 1'b1;
                    got_q.push_back(out_data);
                    last_q.push_back(out_last);
                    addr_q.push_back(mem_addr);
                    st   = 0;
                    have = 1'b0;
                end
            end else begin
                out_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_dump(input string tag, input int exp_done);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
            chk({tag, "_last"}, 32'(last_q[i]), (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        ram[16'h0010] = 16'h1111;
        ram[16'h0011] = 16'h2222;
        ram[16'h0012] = 16'h3333;
        ram[16'h0013] = 16'h4444;
        ram[16'hFFFE] = 16'hAAAA;
        ram[16'hFFFF] = 16'hBBBB;
        ram[16'h0000] = 16'hCCCC;
        ram[16'h0020] = 16'hFFFF;
        ram[16'h0021] = 16'h0002;

        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));

        // basic dump, ready held high
        launch(16'h0010, 16'd3);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_state_load", 32'(dbg_state), 32'(LOAD));
        chk("basic_valid_c1", 32'(out_valid), 32'd0);
        collect(0, 1'b0, 40);
        exp_q = '{16'h1111, 16'h2222, 16'h3333};
        if (CS != 0) exp_q.push_back(16'h6666);
        check_dump("basic", 7 + CS);

        // backpressure: ready low for 3 cycles on every word
        launch(16'h0010, 16'd3);
        collect(3, 1'b0, 60);
        check_dump("bp", 5 * 3 + 1 + CS * 4);

        // address wrap
        launch(16'hFFFE, 16'd3);
        collect(0, 1'b0, 40);
        exp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        if (CS != 0) exp_q.push_back(16'h3331);
        check_dump("wrap", 7 + CS);
        chk("wrap_addr0", 32'(addr_q[0]), 32'h0000FFFE);
        chk("wrap_addr1", 32'(addr_q[1]), 32'h0000FFFF);
        chk("wrap_addr2", 32'(addr_q[2]), 32'h00000000);

        // zero length
        launch(16'h0010, 16'd0);
        collect(0, 1'b0, 10);
        exp_q.delete();
        if (CS != 0) exp_q.push_back(16'h0000);
        check_dump("zero", 1 + CS);

        // stray start mid-dump is ignored
        launch(16'h0010, 16'd3);
        collect(0, 1'b1, 40);
        exp_q = '{16'h1111, 16'h2222, 16'h3333};
        if (CS != 0) exp_q.push_back(16'h6666);
        check_dump("stray", 7 + CS);
        tick();
        tick();
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_valid", 32'(out_valid), 32'd0);

        // reset while word 2 of 4 is valid
        out_ready = 1'b0;
        launch(16'h0010, 16'd4);
        tick();
        chk("mid_w1_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("mid_w2_valid", 32'(out_valid), 32'd1);
        chk("mid_w2_data", 32'(out_data), 32'h00002222);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        out_ready = 1'b1;
        launch(16'h0012, 16'd1);
        collect(0, 1'b0, 20);
        exp_q = '{16'h3333};
        if (CS != 0) exp_q.push_back(16'h3333);
        check_dump("fresh", 3 + CS);
        chk("fresh_addr", 32'(addr_q[0]), 32'h00000012);

`ifdef MEM_DUMP_CHECKSUM_EN
        // checksum wraps modulo 2^WIDTH
        launch(16'h0020, 16'd2);
        collect(0, 1'b0, 40);
        exp_q = '{16'hFFFF, 16'h0002, 16'h0001};
        check_dump("csum", 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
